// File: rtl/ntt_butterfly_stage_if.sv
// Vector stream bundle for the NTT butterfly stage.
// Master drives permuted vectors and twiddles; slave returns results.
interface ntt_butterfly_stage_if #(
    parameter int DATA_WIDTH = 28,
    parameter int LANES      = 128
);
    logic                              in_start;
    logic [LANES*DATA_WIDTH-1:0]       in_data;
    logic [(LANES/2)*DATA_WIDTH-1:0]   tw_data;
    logic                              out_start;
    logic                              out_valid;
    logic [LANES*DATA_WIDTH-1:0]       out_data;

    modport master (
        output in_start, in_data, tw_data,
        input  out_start, out_valid, out_data
    );

    modport slave (
        input  in_start, in_data, tw_data,
        output out_start, out_valid, out_data
    );
endinterface

// File: rtl/ntt_butterfly_stage.sv
// Radix-2 Cooley-Tukey butterfly stage with Barrett reduction.
// Five register stages give four cycles from sample edge to output.
module ntt_butterfly_stage #(
    parameter int          DATA_WIDTH   = 28,
    parameter int          LANES        = 128,
    parameter int unsigned MODULUS      = 132120577,
    parameter int          BLOCK_CYCLES = 16,
    parameter int          LATENCY      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ntt_butterfly_stage_if.slave bus
);
    localparam int DW   = DATA_WIDTH;
    localparam int HALF = LANES / 2;
    localparam int PW   = 2 * DW;
    localparam int PW1  = PW + 1;
    localparam int DW1  = DW + 1;
    localparam int MW   = PW - $clog2(MODULUS) + 2;
    localparam int XW   = PW + MW;
    localparam int CW   = $clog2(BLOCK_CYCLES + 1);

    localparam logic [PW1-1:0] ONE_P = PW1'(1);
    localparam logic [XW-1:0]  MU    = XW'((ONE_P << PW) / PW1'(MODULUS));
    localparam logic [PW-1:0]  Q_P   = PW'(MODULUS);
    localparam logic [DW1-1:0] Q_1   = DW1'(MODULUS);
    localparam logic [DW-1:0]  Q_D   = DW'(MODULUS);
    localparam logic [CW-1:0]  LAST  = CW'(BLOCK_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tag_v, tag_s;
    logic [LATENCY:0] vld_q, sta_q;

    logic [DW-1:0] a_in [HALF];
    logic [DW-1:0] b_in [HALF];
    logic [DW-1:0] w_in [HALF];
    logic [DW-1:0] a1_q [HALF];
    logic [DW-1:0] b1_q [HALF];
    logic [DW-1:0] w1_q [HALF];
    logic [DW-1:0] a2_q [HALF];
    logic [PW-1:0] p2_q [HALF];
    logic [PW-1:0] p2_d [HALF];
    logic [DW-1:0] a3_q [HALF];
    logic [PW-1:0] p3_q [HALF];
    logic [MW-1:0] qe3_q [HALF];
    logic [MW-1:0] qe3_d [HALF];
    logic [DW-1:0] a4_q [HALF];
    logic [DW-1:0] t4_q [HALF];
    logic [DW-1:0] t4_d [HALF];
    logic [DW-1:0] o_q [LANES];
    logic [DW-1:0] o_d [LANES];

    // Frame intake: tag each sampled vector with start/valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_v   = 1'b0;
        tag_s   = 1'b0;
        if (bus.in_start) begin
            tag_v   = 1'b1;
            tag_s   = 1'b1;
            state_d = RUN;
            cnt_d   = CW'(1);
        end else if (state_q == RUN) begin
            tag_v = 1'b1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // FSM state and tag shift register travelling with the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
            sta_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= {vld_q[LATENCY-1:0], tag_v};
            sta_q   <= {sta_q[LATENCY-1:0], tag_s};
        end
    end

    // Lane unpack, multiply, Barrett reduce, then add/sub mod q.
    always_comb begin
        logic [XW-1:0]  prod;
        logic [PW-1:0]  rf;
        logic [DW1-1:0] r;
        logic [DW1-1:0] s;
        prod = '0;
        rf   = '0;
        r    = '0;
        s    = '0;
        for (int k = 0; k < HALF; k++) begin
            a_in[k] = bus.in_data[k*DW +: DW];
            b_in[k] = bus.in_data[(k+HALF)*DW +: DW];
            w_in[k] = bus.tw_data[k*DW +: DW];
            p2_d[k] = PW'(w1_q[k]) * PW'(b1_q[k]);
            prod     = XW'(p2_q[k]) * MU;
            qe3_d[k] = MW'(prod >> PW);
            rf = p3_q[k] - PW'(qe3_q[k]) * Q_P;
            r  = DW1'(rf);
            if (r >= Q_1) begin
                r = r - Q_1;
            end
            t4_d[k] = r[DW-1:0];
            s = {1'b0, a4_q[k]} + {1'b0, t4_q[k]};
            if (s >= Q_1) begin
                s = s - Q_1;
            end
            o_d[k] = s[DW-1:0];
            if (a4_q[k] >= t4_q[k]) begin
                o_d[k+HALF] = a4_q[k] - t4_q[k];
            end else begin
                o_d[k+HALF] = a4_q[k] + Q_D - t4_q[k];
            end
        end
    end

    // Datapath registers; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < HALF; k++) begin
                a1_q[k]  <= '0;
                b1_q[k]  <= '0;
                w1_q[k]  <= '0;
                a2_q[k]  <= '0;
                p2_q[k]  <= '0;
                a3_q[k]  <= '0;
                p3_q[k]  <= '0;
                qe3_q[k] <= '0;
                a4_q[k]  <= '0;
                t4_q[k]  <= '0;
            end
            for (int i = 0; i < LANES; i++) begin
                o_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < HALF; k++) begin
                a1_q[k]  <= a_in[k];
                b1_q[k]  <= b_in[k];
                w1_q[k]  <= w_in[k];
                a2_q[k]  <= a1_q[k];
                p2_q[k]  <= p2_d[k];
                a3_q[k]  <= a2_q[k];
                p3_q[k]  <= p2_q[k];
                qe3_q[k] <= qe3_d[k];
                a4_q[k]  <= a3_q[k];
                t4_q[k]  <= t4_d[k];
            end
            for (int i = 0; i < LANES; i++) begin
                o_q[i] <= o_d[i];
            end
        end
    end

    // Pack result lanes onto the output bus.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.out_data[i*DW +: DW] = o_q[i];
        end
    end

    assign bus.out_start = sta_q[LATENCY];
    assign bus.out_valid = vld_q[LATENCY];
endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// Directed bench for ntt_butterfly_stage: arithmetic, wrap, framing, reset.
// Every step also checks out_data against a 64-bit reference model.
module tb_ntt_butterfly_stage;
    localparam int DW    = 28;
    localparam int LANES = 128;
    localparam int HALF  = 64;
    localparam int W     = LANES * DW;
    localparam int TWW   = HALF * DW;
    localparam int NH    = 512;
    localparam longint unsigned Q = 64'd132120577;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ntt_butterfly_stage_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus();

    ntt_butterfly_stage #(
        .DATA_WIDTH(DW), .LANES(LANES), .MODULUS(132120577),
        .BLOCK_CYCLES(16), .LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0, t1;
    logic [W-1:0] exp_d [NH];
    bit exp_c [NH];
    bit vh [NH];
    bit sh [NH];

    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input logic [TWW-1:0] t);
        logic [W-1:0] r;
        longint unsigned a, b, w, m;
        r = '0;
        for (int k = 0; k < HALF; k++) begin
            a = 64'(d[k*DW +: DW]);
            b = 64'(d[(k+HALF)*DW +: DW]);
            w = 64'(t[k*DW +: DW]);
            m = (w * b) % Q;
            r[k*DW +: DW]        = DW'((a + m) % Q);
            r[(k+HALF)*DW +: DW] = DW'((a + Q - m) % Q);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s cyc %0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
        int bad;
        bad = 0;
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            for (int i = LANES - 1; i >= 0; i--)
                if (got[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
            $error("FAIL %s cyc %0d lane %0d got=%0d exp=%0d", tag, cyc,
                   bad, got[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    task automatic chk_lane(input string tag, input int i,
                            input logic [31:0] exp);
        chk(tag, 32'(bus.out_data[i*DW +: DW]), exp);
    endtask

    task automatic set_uni(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] w);
        for (int k = 0; k < HALF; k++) begin
            bus.in_data[k*DW +: DW]        = a;
            bus.in_data[(k+HALF)*DW +: DW] = b;
            bus.tw_data[k*DW +: DW]        = w;
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < LANES; i++)
            bus.in_data[i*DW +: DW] = DW'($urandom_range(32'(Q - 1), 0));
        for (int k = 0; k < HALF; k++)
            bus.tw_data[k*DW +: DW] = DW'($urandom_range(32'(Q - 1), 0));
    endtask

    task automatic step(input logic s);
        if (cyc + 6 >= NH) begin
            $display("FAIL history overflow at cyc %0d", cyc);
            $fatal(1);
        end
        bus.in_start = s;
        if (rst) begin
            for (int i = 1; i <= 5; i++) begin
                exp_d[cyc+i] = '0;
                exp_c[cyc+i] = 1'b1;
            end
        end else begin
            exp_d[cyc+5] = model(bus.in_data, bus.tw_data);
            exp_c[cyc+5] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        vh[cyc] = bus.out_valid;
        sh[cyc] = bus.out_start;
        if (exp_c[cyc]) chk_vec("data", bus.out_data, exp_d[cyc]);
    endtask

    function automatic int cntv(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) n += int'(vh[i]);
        return n;
    endfunction

    function automatic int cnts(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) n += int'(sh[i]);
        return n;
    endfunction

    initial begin
        rst = 1'b1;
        bus.in_start = 1'b0;
        bus.in_data  = '0;
        bus.tw_data  = '0;
        repeat (3) step(1'b0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_start", 32'(bus.out_start), 0);
        chk_lane("rst_data", 0, 0);
        rst = 1'b0;

        set_uni(5, 3, 1);
        t0 = cyc + 1;
        step(1'b1);
        repeat (3) step(1'b0);
        chk("f1_early", 32'(bus.out_valid), 0);
        step(1'b0);
        chk("f1_start", 32'(bus.out_start), 1);
        chk("f1_valid", 32'(bus.out_valid), 1);
        chk_lane("f1_lo0", 0, 8);
        chk_lane("f1_lo63", 63, 8);
        chk_lane("f1_hi64", 64, 2);
        chk_lane("f1_hi127", 127, 2);
        repeat (20) step(1'b0);
        chk("f1_vcount", 32'(cntv(t0, t0 + 24)), 16);
        chk("f1_vlast", 32'(vh[t0+19]), 1);
        chk("f1_vend", 32'(vh[t0+20]), 0);
        chk("f1_scount", 32'(cnts(t0, t0 + 24)), 1);

        set_uni(DW'(Q - 1), 1, 1);
        repeat (5) step(1'b0);
        chk_lane("wrap_lo", 0, 0);
        chk_lane("wrap_hi", 64, 32'(Q - 2));
        set_uni(0, 1, 1);
        repeat (5) step(1'b0);
        chk_lane("zero_lo", 0, 1);
        chk_lane("zero_hi", 64, 32'(Q - 1));
        set_uni(0, DW'(Q - 1), DW'(Q - 1));
        repeat (5) step(1'b0);
        chk_lane("maxp_lo", 5, 1);
        chk_lane("maxp_hi", 69, 32'(Q - 1));

        t0 = cyc + 1;
        repeat (10) begin
            rand_vec();
            step(1'b0);
        end
        repeat (5) step(1'b0);
        chk("idle_vcount", 32'(cntv(t0 - 15, cyc)), 0);
        chk("idle_scount", 32'(cnts(t0 - 15, cyc)), 0);

        set_uni(7, 11, 13);
        t0 = cyc + 1;
        step(1'b1);
        repeat (15) step(1'b0);
        step(1'b1);
        repeat (24) step(1'b0);
        chk("b2b_vcount", 32'(cntv(t0, t0 + 40)), 32);
        chk("b2b_pre", 32'(vh[t0+3]), 0);
        chk("b2b_first", 32'(vh[t0+4]), 1);
        chk("b2b_last", 32'(vh[t0+35]), 1);
        chk("b2b_end", 32'(vh[t0+36]), 0);
        chk("b2b_s0", 32'(sh[t0+4]), 1);
        chk("b2b_s1", 32'(sh[t0+20]), 1);
        chk("b2b_scount", 32'(cnts(t0, t0 + 40)), 2);

        repeat (5) step(1'b0);
        t0 = cyc + 1;
        step(1'b1);
        repeat (4) step(1'b0);
        step(1'b1);
        repeat (25) step(1'b0);
        chk("rs_s0", 32'(sh[t0+4]), 1);
        chk("rs_s1", 32'(sh[t0+9]), 1);
        chk("rs_scount", 32'(cnts(t0, t0 + 30)), 2);
        chk("rs_vcount", 32'(cntv(t0, t0 + 30)), 21);
        chk("rs_vlast", 32'(vh[t0+24]), 1);
        chk("rs_vend", 32'(vh[t0+25]), 0);

        repeat (3) step(1'b0);
        set_uni(9, 4, 6);
        t0 = cyc + 1;
        step(1'b1);
        repeat (7) step(1'b0);
        rst = 1'b1;
        step(1'b1);
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_start", 32'(bus.out_start), 0);
        chk_lane("mr_data", 0, 0);
        rst = 1'b0;
        repeat (12) step(1'b0);
        chk("mr_pre", 32'(cntv(t0 + 4, t0 + 7)), 4);
        chk("mr_vcount", 32'(cntv(t0 + 8, t0 + 20)), 0);
        chk("mr_scount", 32'(cnts(t0 + 8, t0 + 20)), 0);

        t1 = cyc + 1;
        step(1'b1);
        repeat (22) step(1'b0);
        chk("nf_pre", 32'(sh[t1+3]), 0);
        chk("nf_start", 32'(sh[t1+4]), 1);
        chk("nf_vcount", 32'(cntv(t1, t1 + 22)), 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ntt_butterfly_stage.md
Name: ntt_butterfly_stage

Overview:
- Radix-2 modular butterfly stage that sits directly downstream of a stage permutation block in the N=2048, 128-lane NTT pipeline.
- Consumes one full LANES-wide permuted vector per cycle, framed by a start pulse, and computes LANES/2 Cooley-Tukey butterflies against supplied twiddles.
- Emits the result vector with a fixed pipeline latency and a re-timed start/valid framing for the next permutation stage.

Parameters:
- DATA_WIDTH, 28, bits per coefficient.
- LANES, 128, coefficients per cycle; must be even.
- MODULUS, 132120577, NTT prime q; requires q < 2^DATA_WIDTH.
- BLOCK_CYCLES, 16, vectors per NTT frame (2048/LANES).
- LATENCY, 4, fixed cycles from input sample to output.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_start  in  1  one-cycle pulse; marks the first vector of a frame on in_data.
- in_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; every value < q.
- tw_data  in  (LANES/2)*DATA_WIDTH  twiddle k for pair k, same packing; sampled with in_data; every value < q.
- out_start  out  1  one-cycle pulse aligned with the first result vector of a frame.
- out_valid  out  1  high for each result vector belonging to a frame.
- out_data  out  LANES*DATA_WIDTH  result lanes, same packing as in_data.

Behaviour:
- Pairing: pair k (0 <= k < LANES/2) uses a = lane k, b = lane k+LANES/2, w = tw k.
- Outputs: lane k = (a + w*b) mod q; lane k+LANES/2 = (a - w*b) mod q.
- All outputs are in [0, q). Out-of-range inputs are undefined.
- Modular reduction method is free (Barrett or Montgomery-free is recommended). Full-width product is 2*DATA_WIDTH bits. No truncation before reduction.
- Latency is exactly LATENCY cycles for data, start and valid alike:
  - in_data/tw_data sampled at edge T appear on out_data after edge T+LATENCY.
  - out_start follows in_start by LATENCY cycles.
- Intake frame FSM, states IDLE and RUN:
  - IDLE: sampled in_start=1 -> RUN, cnt=1, vector tagged valid and start.
  - RUN: each cycle the vector is tagged valid, cnt++. When cnt==BLOCK_CYCLES-1 is accepted, go to IDLE with cnt=0. Exactly BLOCK_CYCLES vectors per frame.
  - in_start during RUN: restart the frame. That vector is tagged start+valid and cnt=1. The prior frame is truncated and not flagged.
  - in_start on the cycle right after a frame ends: back-to-back frame with no gap in out_valid.
- Vectors sampled in IDLE without in_start are still computed but tagged invalid: out_valid=0, out_start=0.
- Start and valid tags travel in a LATENCY-deep shift register alongside the data.
- Reset values: out_start=0, out_valid=0, out_data=0, FSM=IDLE, cnt=0. All pipeline start/valid tags are cleared.
- Reset mid-frame: the in-flight frame is dropped. Outputs stay 0/invalid until a new in_start propagates, with no partial out_valid. in_start asserted together with rst is ignored.

Test Plan:
- Single frame, every pair a=5, b=3, w=1, in_start at T0 -> out_start at T0+4; out lanes 0..63 = 8, lanes 64..127 = 2; out_valid high exactly 16 cycles.
- Wrap: a=132120576 (q-1), b=1, w=1 -> low lane 0, high lane 132120575. Also a=0, b=1, w=1 -> low 1, high 132120576.
- Max product: a=0, b=q-1, w=q-1 -> w*b mod q = 1, so low lane 1, high lane q-1. Random a/b/w vectors are checked against a bigint model.
- Framing: in_start pulses at T0 and T0+16 -> out_valid continuous 32 cycles with out_start at T0+4 and T0+20. A second in_start at T0+5 -> out_start at T0+9 and valid until T0+24.
- Idle data: in_data toggling with no in_start -> out_valid=0 and out_start=0 throughout.
- Reset at T0+8 mid-frame -> next cycle out_valid=0, out_data=0. Stays invalid until in_start at T1 gives out_start at T1+4.
